// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS-subset control FSM.
// Opcodes, state encoding, ALU op codes and datapath mux select values.
package mc_ctrl_pkg;

   localparam int ALU_OP_W = 4;
   localparam int STATE_W  = 4;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC_R = 4'd2,
      EXEC_I = 4'd3,
      BRANCH = 4'd4,
      ADDR   = 4'd5,
      MEM_RD = 4'd6,
      MEM_WR = 4'd7,
      WB_ALU = 4'd8,
      WB_MEM = 4'd9,
      TRAP   = 4'd10
   } state_t;

   localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 4'd0;
   localparam logic [ALU_OP_W-1:0] ALU_BEQ   = 4'd2;
   localparam logic [ALU_OP_W-1:0] ALU_BNE   = 4'd3;
   localparam logic [ALU_OP_W-1:0] ALU_ADDI  = 4'd6;
   localparam logic [ALU_OP_W-1:0] ALU_ORI   = 4'd7;
   localparam logic [ALU_OP_W-1:0] ALU_LUI   = 4'd8;
   localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd9;
   localparam logic [ALU_OP_W-1:0] ALU_SW    = 4'd10;

   localparam logic [1:0] SRCB_RT      = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;

   typedef struct packed {
      logic                mem_req;
      logic                iord;
      logic                mem_read;
      logic                mem_write;
      logic                ir_write;
      logic                pc_write;
      logic                pc_write_cond;
      logic                branch_ne;
      logic [1:0]          pc_src;
      logic                reg_write;
      logic                reg_dst;
      logic [1:0]          mem_to_reg;
      logic                alu_src_a;
      logic [1:0]          alu_src_b;
      logic [ALU_OP_W-1:0] alu_op;
      logic                illegal;
   } ctrl_t;

   // Successor of DECODE; unknown opcodes land in the absorbing TRAP state.
   function automatic state_t decode_target(input logic [5:0] op);
      case (op)
         OP_RTYPE:               return EXEC_R;
         OP_ADDI, OP_ORI, OP_LUI: return EXEC_I;
         OP_BEQ, OP_BNE:         return BRANCH;
         OP_LW, OP_SW:           return ADDR;
         default:                return TRAP;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Control/handshake bundle between mc_ctrl_fsm (master) and the datapath/memory (slave).
interface mc_ctrl_if;
   import mc_ctrl_pkg::*;

   logic [5:0]          instr_op_i;
   logic                mem_ready_i;
   logic                mem_req_o;
   logic                iord_o;
   logic                mem_read_o;
   logic                mem_write_o;
   logic                ir_write_o;
   logic                pc_write_o;
   logic                pc_write_cond_o;
   logic                branch_ne_o;
   logic [1:0]          pc_src_o;
   logic                reg_write_o;
   logic                reg_dst_o;
   logic [1:0]          mem_to_reg_o;
   logic                alu_src_a_o;
   logic [1:0]          alu_src_b_o;
   logic [ALU_OP_W-1:0] alu_op_o;
   logic                illegal_o;
   logic [31:0]         instr_cnt_o;
   logic [31:0]         stall_cnt_o;

   modport master (
      input  instr_op_i, mem_ready_i,
      output mem_req_o, iord_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o,
             pc_write_cond_o, branch_ne_o, pc_src_o, reg_write_o, reg_dst_o,
             mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o,
             instr_cnt_o, stall_cnt_o
   );

   modport slave (
      output instr_op_i, mem_ready_i,
      input  mem_req_o, iord_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o,
             pc_write_cond_o, branch_ne_o, pc_src_o, reg_write_o, reg_dst_o,
             mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o,
             instr_cnt_o, stall_cnt_o
   );

endinterface

// File: rtl/mc_ctrl_out_dec.sv
// Combinational control-output map from (state, opcode, memory ready, R-type flag).
module mc_ctrl_out_dec
   import mc_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] op,
   input  logic       rtype,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   // Per-state control word; anything not set stays 0.
   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_b = SRCB_IMM_SH2;
            ctrl.alu_op    = ALU_ADD;
         end
         EXEC_R: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_RT;
            ctrl.alu_op    = ALU_RTYPE;
         end
         EXEC_I: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            case (op)
               OP_ORI:  ctrl.alu_op = ALU_ORI;
               OP_LUI:  ctrl.alu_op = ALU_LUI;
               default: ctrl.alu_op = ALU_ADDI;
            endcase
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_RT;
            ctrl.alu_op        = (op == OP_BNE) ? ALU_BNE : ALU_BEQ;
            ctrl.pc_write_cond = 1'b1;
            ctrl.branch_ne     = (op == OP_BNE);
            ctrl.pc_src        = PCSRC_ALUOUT;
         end
         ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            ctrl.alu_op    = (op == OP_SW) ? ALU_SW : ALU_ADD;
         end
         MEM_RD: begin
            ctrl.mem_req  = 1'b1;
            ctrl.iord     = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         MEM_WR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         WB_ALU: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = rtype;
            ctrl.mem_to_reg = M2R_ALUOUT;
         end
         WB_MEM: begin
            ctrl.reg_write  = 1'b1;
            ctrl.reg_dst    = 1'b0;
            ctrl.mem_to_reg = M2R_MDR;
         end
         TRAP:    ctrl.illegal = 1'b1;
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset control FSM with fetch/data memory-port arbitration.
// Optional performance counters enabled by defining MC_CTRL_PERF_CNT_EN.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   mc_ctrl_if.master    bus
);

   state_t state_r;
   state_t next_state_s;
   logic   rtype_r;
   ctrl_t  dec_s;
   ctrl_t  ctrl_s;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_r <= FETCH;
      else       state_r <= next_state_s;
   end

   // R-type flag captured in DECODE so WB_ALU does not depend on the opcode bus.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                  rtype_r <= 1'b0;
      else if (state_r == DECODE) rtype_r <= (bus.instr_op_i == OP_RTYPE);
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         FETCH:          next_state_s = bus.mem_ready_i ? DECODE : FETCH;
         DECODE:         next_state_s = decode_target(bus.instr_op_i);
         EXEC_R, EXEC_I: next_state_s = WB_ALU;
         BRANCH:         next_state_s = FETCH;
         ADDR:           next_state_s = (bus.instr_op_i == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:         next_state_s = bus.mem_ready_i ? WB_MEM : MEM_RD;
         MEM_WR:         next_state_s = bus.mem_ready_i ? FETCH : MEM_WR;
         WB_ALU, WB_MEM: next_state_s = FETCH;
         TRAP:           next_state_s = TRAP;
         default:        next_state_s = FETCH;
      endcase
   end

   mc_ctrl_out_dec u_out_dec (
      .state     (state_r),
      .op        (bus.instr_op_i),
      .rtype     (rtype_r),
      .mem_ready (bus.mem_ready_i),
      .ctrl      (dec_s)
   );

   // Output stage: reset kills every strobe in the same cycle it rises.
   always_comb begin
      if (rst_i) ctrl_s = '0;
      else       ctrl_s = dec_s;
   end

   assign bus.mem_req_o       = ctrl_s.mem_req;
   assign bus.iord_o          = ctrl_s.iord;
   assign bus.mem_read_o      = ctrl_s.mem_read;
   assign bus.mem_write_o     = ctrl_s.mem_write;
   assign bus.ir_write_o      = ctrl_s.ir_write;
   assign bus.pc_write_o      = ctrl_s.pc_write;
   assign bus.pc_write_cond_o = ctrl_s.pc_write_cond;
   assign bus.branch_ne_o     = ctrl_s.branch_ne;
   assign bus.pc_src_o        = ctrl_s.pc_src;
   assign bus.reg_write_o     = ctrl_s.reg_write;
   assign bus.reg_dst_o       = ctrl_s.reg_dst;
   assign bus.mem_to_reg_o    = ctrl_s.mem_to_reg;
   assign bus.alu_src_a_o     = ctrl_s.alu_src_a;
   assign bus.alu_src_b_o     = ctrl_s.alu_src_b;
   assign bus.alu_op_o        = ctrl_s.alu_op;
   assign bus.illegal_o       = ctrl_s.illegal;

`ifdef MC_CTRL_PERF_CNT_EN
   logic [31:0] instr_cnt_r;
   logic [31:0] stall_cnt_r;
   logic        retire_s;

   assign retire_s = (next_state_s == FETCH) &&
                     ((state_r == WB_ALU) || (state_r == WB_MEM) ||
                      (state_r == BRANCH) || (state_r == MEM_WR));

   // Retired-instruction and memory-wait counters, both free-running mod 2^32.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         instr_cnt_r <= 32'd0;
         stall_cnt_r <= 32'd0;
      end else begin
         if (retire_s)                              instr_cnt_r <= instr_cnt_r + 32'd1;
         if (ctrl_s.mem_req && !bus.mem_ready_i)    stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end

   assign bus.instr_cnt_o = instr_cnt_r;
   assign bus.stall_cnt_o = stall_cnt_r;
`else
   assign bus.instr_cnt_o = 32'd0;
   assign bus.stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: per-cycle expected control words go through a scoreboard queue.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

`ifdef MC_CTRL_PERF_CNT_EN
   localparam logic [31:0] PERF_MASK = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] PERF_MASK = 32'h0000_0000;
`endif

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   int         n_checks = 0;
   int         n_fail = 0;
   sb_item_t   sb_q[$];

   mc_ctrl_if bus ();

   mc_ctrl_fsm dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_vec();
      return {10'd0, bus.mem_req_o, bus.iord_o, bus.mem_read_o, bus.mem_write_o,
              bus.ir_write_o, bus.pc_write_o, bus.pc_write_cond_o, bus.branch_ne_o,
              bus.pc_src_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
              bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.illegal_o};
   endfunction

   function automatic logic [31:0] mk(input bit req, input bit iord, input bit rd, input bit wr,
                                      input bit irw, input bit pcw, input bit pcwc, input bit bne,
                                      input logic [1:0] pcsrc, input bit regw, input bit rdst,
                                      input logic [1:0] m2r, input bit srca, input logic [1:0] srcb,
                                      input logic [3:0] aop, input bit ill);
      return {10'd0, req, iord, rd, wr, irw, pcw, pcwc, bne, pcsrc, regw, rdst, m2r, srca, srcb, aop, ill};
   endfunction

   // Expected control words, written directly from the per-state output table.
   function automatic logic [31:0] e_fetch(input bit rdy);
      return mk(1, 0, 1, 0, rdy, rdy, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd1, 4'd9, 0);
   endfunction
   function automatic logic [31:0] e_decode();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd3, 4'd9, 0);
   endfunction
   function automatic logic [31:0] e_exec_r();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 2'd0, 4'd0, 0);
   endfunction
   function automatic logic [31:0] e_exec_i(input logic [3:0] aop);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 2'd2, aop, 0);
   endfunction
   function automatic logic [31:0] e_wb_alu(input bit rdst);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, rdst, 2'd0, 0, 2'd0, 4'd0, 0);
   endfunction
   function automatic logic [31:0] e_branch(input bit ne);
      return mk(0, 0, 0, 0, 0, 0, 1, ne, 2'd1, 0, 0, 2'd0, 1, 2'd0, ne ? 4'd3 : 4'd2, 0);
   endfunction
   function automatic logic [31:0] e_addr(input logic [3:0] aop);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 1, 2'd2, aop, 0);
   endfunction
   function automatic logic [31:0] e_mem_rd();
      return mk(1, 1, 1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0);
   endfunction
   function automatic logic [31:0] e_mem_wr();
      return mk(1, 1, 0, 1, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 0);
   endfunction
   function automatic logic [31:0] e_wb_mem();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 1, 0, 2'd1, 0, 2'd0, 4'd0, 0);
   endfunction
   function automatic logic [31:0] e_trap();
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 4'd0, 1);
   endfunction

   // Drive one cycle of inputs, queue the expected word, compare on the falling edge.
   task automatic step(input logic [5:0] op, input bit rdy, input logic [31:0] e, input string tag);
      sb_item_t item;
      bus.instr_op_i  = op;
      bus.mem_ready_i = rdy;
      sb_q.push_back('{tag, e});
      @(negedge clk_i);
      item = sb_q.pop_front();
      check_eq(item.tag, obs_vec(), item.exp);
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_cnts(input string tag, input logic [31:0] ni, input logic [31:0] ns);
      check_eq({tag, "_instr_cnt"}, bus.instr_cnt_o, ni & PERF_MASK);
      check_eq({tag, "_stall_cnt"}, bus.stall_cnt_o, ns & PERF_MASK);
   endtask

   initial begin
      logic [5:0] iops [2];
      logic [3:0] iaops[2];
      iops[0] = 6'd13; iaops[0] = 4'd7;
      iops[1] = 6'd15; iaops[1] = 4'd8;

      bus.instr_op_i  = 6'd0;
      bus.mem_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      step(6'd0, 1'b1, 32'd0, "reset_outputs_zero");
      check_cnts("reset", 32'd0, 32'd0);
      rst_i = 1'b0;

      // ADDI, zero-wait; opcode bus changed in WB_ALU to prove reg_dst is not re-decoded.
      step(6'd8, 1'b1, e_fetch(1'b1),   "addi_fetch");
      step(6'd8, 1'b1, e_decode(),      "addi_decode");
      step(6'd8, 1'b1, e_exec_i(4'd6),  "addi_exec_i");
      step(6'd0, 1'b1, e_wb_alu(1'b0),  "addi_wb_alu");
      check_cnts("addi", 32'd1, 32'd0);

      // LW with two wait cycles in MEM_RD: 7 cycles total.
      step(6'd35, 1'b1, e_fetch(1'b1),  "lw_fetch");
      step(6'd35, 1'b0, e_decode(),     "lw_decode");
      step(6'd35, 1'b0, e_addr(4'd9),   "lw_addr");
      step(6'd35, 1'b0, e_mem_rd(),     "lw_mem_rd_wait0");
      step(6'd35, 1'b0, e_mem_rd(),     "lw_mem_rd_wait1");
      step(6'd35, 1'b1, e_mem_rd(),     "lw_mem_rd_ready");
      step(6'd35, 1'b0, e_wb_mem(),     "lw_wb_mem");
      check_cnts("lw", 32'd2, 32'd2);

      // BNE: back in FETCH on the fourth cycle.
      step(6'd5, 1'b1, e_fetch(1'b1),   "bne_fetch");
      step(6'd5, 1'b1, e_decode(),      "bne_decode");
      step(6'd5, 1'b1, e_branch(1'b1),  "bne_branch");
      check_cnts("bne", 32'd3, 32'd2);

      // R-type with three fetch wait cycles.
      for (int i = 0; i < 3; i++) step(6'd0, 1'b0, e_fetch(1'b0), "r_fetch_wait");
      step(6'd0, 1'b1, e_fetch(1'b1),   "r_fetch_ready");
      step(6'd0, 1'b1, e_decode(),      "r_decode");
      step(6'd0, 1'b1, e_exec_r(),      "r_exec_r");
      step(6'd8, 1'b1, e_wb_alu(1'b1),  "r_wb_alu");
      check_cnts("rtype", 32'd4, 32'd5);

      // ORI and LUI ALU codes.
      for (int i = 0; i < 2; i++) begin
         step(iops[i], 1'b1, e_fetch(1'b1),    "i_fetch");
         step(iops[i], 1'b1, e_decode(),       "i_decode");
         step(iops[i], 1'b1, e_exec_i(iaops[i]), "i_exec_i");
         step(iops[i], 1'b1, e_wb_alu(1'b0),   "i_wb_alu");
      end

      // BEQ.
      step(6'd4, 1'b1, e_fetch(1'b1),   "beq_fetch");
      step(6'd4, 1'b1, e_decode(),      "beq_decode");
      step(6'd4, 1'b1, e_branch(1'b0),  "beq_branch");

      // SW zero-wait: 4 cycles.
      step(6'd43, 1'b1, e_fetch(1'b1),  "sw_fetch");
      step(6'd43, 1'b1, e_decode(),     "sw_decode");
      step(6'd43, 1'b1, e_addr(4'd10),  "sw_addr");
      step(6'd43, 1'b1, e_mem_wr(),     "sw_mem_wr");
      check_cnts("sw", 32'd8, 32'd5);

      // Unknown opcode traps, stays trapped regardless of inputs.
      step(6'd2, 1'b1, e_fetch(1'b1),   "trap_fetch");
      step(6'd2, 1'b1, e_decode(),      "trap_decode");
      step(6'd2, 1'b1, e_trap(),        "trap_0");
      step(6'd0, 1'b0, e_trap(),        "trap_1");
      step(6'd8, 1'b1, e_trap(),        "trap_2");
      check_cnts("trap", 32'd8, 32'd5);
      rst_i = 1'b1;
      step(6'd0, 1'b1, 32'd0,           "trap_reset_outputs");
      rst_i = 1'b0;
      step(6'd0, 1'b0, e_fetch(1'b0),   "trap_after_reset_fetch");
      check_cnts("trap_reset", 32'd0, 32'd1);

      // Reset asserted mid MEM_WR while memory is stalled.
      step(6'd43, 1'b1, e_fetch(1'b1),  "swr_fetch");
      step(6'd43, 1'b1, e_decode(),     "swr_decode");
      step(6'd43, 1'b1, e_addr(4'd10),  "swr_addr");
      step(6'd43, 1'b0, e_mem_wr(),     "swr_mem_wr_wait");
      bus.mem_ready_i = 1'b0;
      rst_i = 1'b1;
      #1;
      check_eq("swr_reset_drops_outputs", obs_vec(), 32'd0);
      check_cnts("swr_in_reset", 32'd0, 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      step(6'd43, 1'b1, e_fetch(1'b1),  "swr_after_reset_fetch");
      check_eq("swr_instr_cnt_zero", bus.instr_cnt_o, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multi-cycle control FSM for the MIPS subset R-type (op 0), BEQ (4), BNE (5), ADDI (8), ORI (13), LUI (15), LW (35) and SW (43). It sequences a shared-ALU, unified-memory datapath: fetch, decode, execute, memory and writeback each take one or more cycles. It also arbitrates the single memory port between instruction fetch and data access using a req/ready handshake. It sits beside the datapath and replaces the single-cycle opcode decoder.

Parameters:
- ALU_OP_W, 4, width of alu_op_o; codes: 0 R-type (funct decides), 2 BEQ-sub, 3 BNE-sub, 6 ADDI, 7 ORI, 8 LUI, 9 ADD (address/PC), 10 SW-address.
- STATE_W, 4, state register width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- instr_op_i  in  6  opcode field of the instruction register
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request valid
- iord_o  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read_o  out  1  read strobe
- mem_write_o  out  1  write strobe
- ir_write_o  out  1  load instruction register
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if branch condition holds
- branch_ne_o  out  1  condition select: 1 = BNE (not zero), 0 = BEQ
- pc_src_o  out  2  0 = ALU result, 1 = ALUOut
- reg_write_o  out  1  register-file write enable
- reg_dst_o  out  1  1 = rd, 0 = rt
- mem_to_reg_o  out  2  0 = ALUOut, 1 = MDR
- alu_src_a_o  out  1  0 = PC, 1 = rs
- alu_src_b_o  out  2  0 = rt, 1 = const 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
- alu_op_o  out  ALU_OP_W  ALU operation code
- illegal_o  out  1  sticky unknown-opcode trap
- instr_cnt_o  out  32  retired instruction count (optional feature)
- stall_cnt_o  out  32  memory wait cycles (optional feature)

Behaviour:
- Reset:
  - While rst_i is high, state = FETCH and every output is 0 (outputs are gated combinationally by rst_i).
  - Reset mid-operation drops mem_req_o in the same cycle and aborts the instruction with no register, PC or memory write.
- States: FETCH, DECODE, EXEC_R, EXEC_I, BRANCH, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, TRAP.
- FETCH:
  - Drives mem_req_o=1, mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=1, alu_op_o=9, pc_src_o=0.
  - ir_write_o and pc_write_o equal mem_ready_i (Mealy gating).
  - Stays in FETCH while mem_ready_i=0; goes to DECODE when it is 1.
- DECODE: alu_src_a_o=0, alu_src_b_o=3, alu_op_o=9 (computes branch target into ALUOut). Next state by instr_op_i:
  - 0 -> EXEC_R
  - 8, 13, 15 -> EXEC_I
  - 4, 5 -> BRANCH
  - 35, 43 -> ADDR
  - any other opcode -> TRAP
- EXEC_R: alu_src_a_o=1, alu_src_b_o=0, alu_op_o=0; next WB_ALU.
- EXEC_I: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=6/7/8 for ADDI/ORI/LUI; next WB_ALU.
- WB_ALU: reg_write_o=1, mem_to_reg_o=0, reg_dst_o=1 for R-type, 0 otherwise; next FETCH.
- BRANCH:
  - alu_src_a_o=1, alu_src_b_o=0, alu_op_o=2 (BEQ) or 3 (BNE).
  - pc_write_cond_o=1, branch_ne_o=(op==5), pc_src_o=1; next FETCH.
- ADDR: alu_src_a_o=1, alu_src_b_o=2, alu_op_o=9 (LW) or 10 (SW); next MEM_RD (op 35) or MEM_WR (op 43).
- MEM_RD / MEM_WR:
  - mem_req_o=1, iord_o=1, and mem_read_o=1 or mem_write_o=1 respectively.
  - Hold the state until mem_ready_i=1; then MEM_RD -> WB_MEM, MEM_WR -> FETCH.
- WB_MEM: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1; next FETCH.
- TRAP: illegal_o=1, all strobes 0; absorbing until reset.
- Minimum cycles with zero-wait memory: R/I-ALU 4, branch 3, LW 5, SW 4. Each wait cycle adds 1.
- instr_op_i is sampled only in DECODE, BRANCH, EXEC_I and ADDR; the instruction register is stable from DECODE until the next FETCH completes.
- Unlisted outputs in any state are 0. No output is ever X.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.

Optional Feature:
- MC_CTRL_PERF_CNT_EN defined:
  - instr_cnt_o increments on each transition into FETCH from WB_ALU, WB_MEM, BRANCH or MEM_WR.
  - stall_cnt_o increments each cycle that mem_req_o=1 and mem_ready_i=0.
  - Both counters are 32-bit, wrap modulo 2^32 and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LUI, OP_LW, OP_SW);
  - the state enum;
  - ALU op codes;
  - ALUSrcB, PCSrc and MemToReg select constants.
- Sub-module mc_ctrl_out_dec: a combinational map from (state, opcode, mem_ready_i) to control outputs. The top keeps the state register and the counters.

Test Plan:
- ADDI (op 8), zero-wait memory -> states FETCH, DECODE, EXEC_I, WB_ALU; reg_write_o=1 with reg_dst_o=0 in cycle 4; alu_op_o=6 in cycle 3.
- LW (op 35), mem_ready_i low for 2 cycles in MEM_RD -> total 7 cycles; mem_req_o=1 and iord_o=1 for 3 cycles; stall_cnt_o=2 (macro on).
- BNE (op 5) -> BRANCH with pc_write_cond_o=1, branch_ne_o=1, pc_src_o=1, alu_op_o=3; back in FETCH on cycle 4.
- Fetch with mem_ready_i low 3 cycles -> ir_write_o and pc_write_o stay 0 until the ready cycle, then pulse for exactly one cycle.
- Op 6'd2 (unknown) -> TRAP after DECODE; illegal_o=1 persists; no strobes; rst_i pulse returns to FETCH with illegal_o=0.
- rst_i asserted during MEM_WR with mem_ready_i=0 -> mem_req_o and mem_write_o drop immediately; after release, FETCH; instr_cnt_o=0.
